// File: rtl/fwd_sel_pipe_pkg.sv
// Shared datapath widths and forwarding-select encodings for the EX-stage operand muxes.
package fwd_sel_pipe_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned FWD_SEL_W = 2;

  // Encodings shared with the hazard/forwarding unit
  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2,
    FWD_IMM   = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/fwd_sel_pipe_stage.sv
// One pipeline register stage carrying valid, data and select with stall/flush control.
module fwd_sel_pipe_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  logic [SEL_W-1:0] prev_sel,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [SEL_W-1:0] sel
);

  // Flush beats stall; data is captured regardless of valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      sel   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      data  <= '0;
      sel   <= '0;
    end else if (!stall) begin
      valid <= prev_valid;
      data  <= prev_data;
      sel   <= prev_sel;
    end
  end

endmodule

// File: rtl/fwd_sel_pipe.sv
// N-input operand-select mux with LAT registered stages and out-of-range select tracking.
module fwd_sel_pipe
  import fwd_sel_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = DATA_W,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = FWD_SEL_W,
  parameter int unsigned LAT    = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    clr_err,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        data_out,
  output logic [SEL_W-1:0]        sel_out,
  output logic                    err_sticky,
  output logic [CNT_W-1:0]        err_cnt
);

  if (LAT < 1 || LAT > 3) begin : g_bad_lat
    $error("fwd_sel_pipe: LAT must be 1..3");
  end
  if (NUM_IN < 2) begin : g_bad_num_in
    $error("fwd_sel_pipe: NUM_IN must be at least 2");
  end
  if ((64'd1 << SEL_W) < 64'(NUM_IN)) begin : g_bad_sel_w
    $error("fwd_sel_pipe: SEL_W too narrow for NUM_IN");
  end

  logic [WIDTH-1:0] pick_c;
  logic             oor_c;
  logic             accept_oor_c;

  // Unmatched selects fall through to zero data and the out-of-range flag
  always_comb begin
    pick_c = '0;
    oor_c  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        pick_c = data_in[k*WIDTH +: WIDTH];
        oor_c  = 1'b0;
      end
    end
  end

  logic             stg_valid [LAT];
  logic [WIDTH-1:0] stg_data  [LAT];
  logic [SEL_W-1:0] stg_sel   [LAT];

  for (genvar i = 0; i < LAT; i++) begin : g_stage
    if (i == 0) begin : g_head
      fwd_sel_pipe_stage #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_stage (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .prev_valid (in_valid),
        .prev_data  (pick_c),
        .prev_sel   (sel),
        .valid      (stg_valid[i]),
        .data       (stg_data[i]),
        .sel        (stg_sel[i])
      );
    end else begin : g_tail
      fwd_sel_pipe_stage #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_stage (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .prev_valid (stg_valid[i-1]),
        .prev_data  (stg_data[i-1]),
        .prev_sel   (stg_sel[i-1]),
        .valid      (stg_valid[i]),
        .data       (stg_data[i]),
        .sel        (stg_sel[i])
      );
    end
  end

  assign out_valid = stg_valid[LAT-1];
  assign data_out  = stg_data[LAT-1];
  assign sel_out   = stg_sel[LAT-1];

  assign accept_oor_c = in_valid & ~stall & ~flush & oor_c;

  // Clear takes effect before a same-edge increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (clr_err) begin
      err_sticky <= accept_oor_c;
      err_cnt    <= accept_oor_c ? CNT_W'(1) : '0;
    end else if (accept_oor_c) begin
      err_sticky <= 1'b1;
      if (err_cnt != {CNT_W{1'b1}}) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_sel_pipe.sv
// Directed bench over four configurations of fwd_sel_pipe sharing one stimulus bus.
module tb_fwd_sel_pipe;

  localparam logic [31:0] DA = 32'hAAAA0000;
  localparam logic [31:0] DB = 32'hBBBB0001;
  localparam logic [31:0] DC = 32'hCCCC0002;
  localparam logic [31:0] DD = 32'hDDDD0003;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [1:0]   sel;
  logic [127:0] data_in;
  logic         stall;
  logic         flush;
  logic         clr_err;

  logic        v1, v2, v3, v4;
  logic [31:0] d1, d2, d3, d4;
  logic [1:0]  s1, s2, s3, s4;
  logic        e1, e2, e3, e4;
  logic [7:0]  c1, c2, c3;
  logic [1:0]  c4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_sel_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .LAT(1), .CNT_W(8)) u_lat1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sel(sel), .data_in(data_in),
    .stall(stall), .flush(flush), .clr_err(clr_err), .out_valid(v1),
    .data_out(d1), .sel_out(s1), .err_sticky(e1), .err_cnt(c1));

  fwd_sel_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .LAT(2), .CNT_W(8)) u_lat2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sel(sel), .data_in(data_in),
    .stall(stall), .flush(flush), .clr_err(clr_err), .out_valid(v2),
    .data_out(d2), .sel_out(s2), .err_sticky(e2), .err_cnt(c2));

  fwd_sel_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .LAT(3), .CNT_W(8)) u_lat3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sel(sel), .data_in(data_in),
    .stall(stall), .flush(flush), .clr_err(clr_err), .out_valid(v3),
    .data_out(d3), .sel_out(s3), .err_sticky(e3), .err_cnt(c3));

  fwd_sel_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .LAT(1), .CNT_W(2)) u_oor (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sel(sel), .data_in(data_in[95:0]),
    .stall(stall), .flush(flush), .clr_err(clr_err), .out_valid(v4),
    .data_out(d4), .sel_out(s4), .err_sticky(e4), .err_cnt(c4));

  typedef struct {
    logic        in_valid;
    logic [1:0]  sel;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [1:0]  exp_sel;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [1:0] s);
    in_valid = v;
    sel      = s;
    tick();
  endtask

  vec_t sweep [6];
  logic [1:0] sat_exp [5];

  initial begin
    sweep[0] = '{1'b1, 2'd0, 1'b1, DA, 2'd0};
    sweep[1] = '{1'b1, 2'd1, 1'b1, DB, 2'd1};
    sweep[2] = '{1'b1, 2'd2, 1'b1, DC, 2'd2};
    sweep[3] = '{1'b1, 2'd3, 1'b1, DD, 2'd3};
    sweep[4] = '{1'b0, 2'd2, 1'b0, DC, 2'd2};
    sweep[5] = '{1'b1, 2'd1, 1'b1, DB, 2'd1};
    sat_exp  = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    rst = 1'b1; in_valid = 1'b0; sel = 2'd0; stall = 1'b0; flush = 1'b0; clr_err = 1'b0;
    data_in = {DD, DC, DB, DA};
    #2;
    chk("rst_valid_lat1", 32'(v1), 32'd0);
    chk("rst_data_lat1", d1, 32'd0);
    chk("rst_valid_lat3", 32'(v3), 32'd0);
    chk("rst_cnt_oor", 32'(c4), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Select sweep on LAT=1
    for (int i = 0; i < 6; i++) begin
      beat(sweep[i].in_valid, sweep[i].sel);
      chk($sformatf("sweep%0d_valid", i), 32'(v1), 32'(sweep[i].exp_valid));
      chk($sformatf("sweep%0d_data", i), d1, sweep[i].exp_data);
      chk($sformatf("sweep%0d_sel", i), 32'(s1), 32'(sweep[i].exp_sel));
    end

    // Stall hold on LAT=3
    for (int i = 0; i < 3; i++) beat(1'b0, 2'd0);
    beat(1'b1, 2'd0);
    beat(1'b1, 2'd1);
    beat(1'b1, 2'd2);
    chk("stall_pre_valid", 32'(v3), 32'd1);
    chk("stall_pre_data", d3, DA);
    stall = 1'b1;
    beat(1'b1, 2'd3);
    chk("stall1_data", d3, DA);
    chk("stall1_valid", 32'(v3), 32'd1);
    beat(1'b1, 2'd3);
    chk("stall2_data", d3, DA);
    stall = 1'b0;
    beat(1'b0, 2'd0);
    chk("resume_b_data", d3, DB);
    chk("resume_b_valid", 32'(v3), 32'd1);
    beat(1'b0, 2'd0);
    chk("resume_c_data", d3, DC);
    beat(1'b0, 2'd0);
    chk("resume_idle_valid", 32'(v3), 32'd0);

    // Flush together with stall on LAT=3
    beat(1'b1, 2'd0);
    beat(1'b1, 2'd1);
    beat(1'b1, 2'd2);
    chk("flush_pre_valid", 32'(v3), 32'd1);
    stall = 1'b1;
    flush = 1'b1;
    beat(1'b1, 2'd3);
    chk("flush_valid", 32'(v3), 32'd0);
    chk("flush_data", d3, 32'd0);
    stall = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat(1'b0, 2'd0);
      chk($sformatf("flush_drain%0d_valid", i), 32'(v3), 32'd0);
    end

    // Out-of-range select with NUM_IN=3, CNT_W=2
    clr_err = 1'b1;
    beat(1'b0, 2'd0);
    clr_err = 1'b0;
    chk("clr_cnt", 32'(c4), 32'd0);
    chk("clr_sticky", 32'(e4), 32'd0);
    beat(1'b1, 2'd2);
    chk("oor_inrange_data", d4, DC);
    chk("oor_inrange_cnt", 32'(c4), 32'd0);
    beat(1'b1, 2'd3);
    chk("oor_data", d4, 32'd0);
    chk("oor_valid", 32'(v4), 32'd1);
    chk("oor_sel", 32'(s4), 32'd3);
    chk("oor_sticky", 32'(e4), 32'd1);
    chk("oor_cnt", 32'(c4), 32'd1);
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, 2'd3);
      chk($sformatf("sat%0d_cnt", i), 32'(c4), 32'(sat_exp[i]));
    end
    beat(1'b0, 2'd3);
    chk("oor_invalid_cnt", 32'(c4), 32'd3);

    // clr_err coinciding with accepted and stalled oor beats
    clr_err = 1'b1;
    beat(1'b1, 2'd3);
    chk("clr_accept_cnt", 32'(c4), 32'd1);
    chk("clr_accept_sticky", 32'(e4), 32'd1);
    stall = 1'b1;
    beat(1'b1, 2'd3);
    chk("clr_stall_cnt", 32'(c4), 32'd0);
    chk("clr_stall_sticky", 32'(e4), 32'd0);
    stall = 1'b0;
    clr_err = 1'b0;

    // Asynchronous reset mid-stream on LAT=2
    beat(1'b1, 2'd3);
    beat(1'b1, 2'd0);
    chk("stream_valid", 32'(v2), 32'd1);
    chk("stream_data", d2, DD);
    chk("stream_cnt_oor", 32'(c4), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(v2), 32'd0);
    chk("async_rst_data", d2, 32'd0);
    chk("async_rst_sel", 32'(s2), 32'd0);
    chk("async_rst_cnt", 32'(c4), 32'd0);
    chk("async_rst_sticky", 32'(e4), 32'd0);
    rst = 1'b0;
    beat(1'b1, 2'd1);
    chk("post_rst_edge1_valid", 32'(v2), 32'd0);
    beat(1'b0, 2'd0);
    chk("post_rst_edge2_valid", 32'(v2), 32'd1);
    chk("post_rst_edge2_data", d2, DB);
    beat(1'b0, 2'd0);
    chk("post_rst_edge3_valid", 32'(v2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
